// File: rtl/demux6_pkg.sv
// Shared constants and types for the six-way result distributor.
package demux6_pkg;

  localparam int WIDTH = 64;
  localparam int N_OUT = 6;

  // Select codes above the lane indices.
  localparam logic [2:0] SEL_DROP  = 3'd6;
  localparam logic [2:0] SEL_BCAST = 3'd7;

  typedef enum logic {
    LANE_EMPTY = 1'b0,
    LANE_FULL  = 1'b1
  } lane_state_t;

endpackage

// File: rtl/demux_lane.sv
// One output lane: a single-entry buffer with a load strobe and valid/ready.
// A pop and a load in the same cycle keep the lane FULL with the new word,
// so the lane sustains one word per cycle.
module demux_lane
  import demux6_pkg::*;
#(
  parameter int W = WIDTH
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic         can_take
);

  lane_state_t  state_reg;
  lane_state_t  state_next;
  logic [W-1:0] data_reg;

  // State register: reset empties the lane.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= LANE_EMPTY;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next state: a load always wins over a pop.
  always_comb begin
    state_next = state_reg;
    if (load) begin
      state_next = LANE_FULL;
    end else if (state_reg == LANE_FULL && out_ready) begin
      state_next = LANE_EMPTY;
    end
  end

  // Outputs: valid mirrors the state; a lane takes a word if empty or draining.
  always_comb begin
    out_valid = (state_reg == LANE_FULL);
    out_data  = data_reg;
    can_take  = (state_reg == LANE_EMPTY) || out_ready;
  end

  // Data buffer: only written on load, so it holds stable while stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_reg <= '0;
    end else if (load) begin
      data_reg <= load_data;
    end
  end

endmodule

// File: rtl/demux6_router.sv
// Six-way 64-bit distributor: routes each accepted word to one lane, to all
// lanes (broadcast), or drops it while flagging the bad select.
module demux6_router
  import demux6_pkg::*;
#(
  parameter int WIDTH = demux6_pkg::WIDTH,
  parameter int N_OUT = demux6_pkg::N_OUT,
  parameter int CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_data,
  input  logic [2:0]             in_sel,
  output logic [N_OUT-1:0]       out_valid,
  input  logic [N_OUT-1:0]       out_ready,
  output logic [N_OUT*WIDTH-1:0] out_data,
  output logic                   err_sel,
  output logic [CNT_W-1:0]       drop_cnt
);

  logic [N_OUT-1:0] can_take;
  logic [N_OUT-1:0] sel_hit;
  logic [N_OUT-1:0] lane_load;
  logic             accept;
  logic             drop_accept;
  logic             err_sel_reg;
  logic [CNT_W-1:0] drop_cnt_reg;

  assign accept      = in_valid && in_ready;
  assign drop_accept = accept && (in_sel == SEL_DROP);

  // Per-lane select decode and lane instances.
  for (genvar gi = 0; gi < N_OUT; gi++) begin : g_lane
    assign sel_hit[gi]   = (in_sel == 3'(gi));
    assign lane_load[gi] = accept && (sel_hit[gi] || in_sel == SEL_BCAST);

    demux_lane #(
      .W(WIDTH)
    ) u_lane (
      .clk       (clk),
      .reset     (reset),
      .load      (lane_load[gi]),
      .load_data (in_data),
      .out_ready (out_ready[gi]),
      .out_valid (out_valid[gi]),
      .out_data  (out_data[gi*WIDTH +: WIDTH]),
      .can_take  (can_take[gi])
    );
  end

  // Input ready: drops never stall, broadcast needs every lane free.
  always_comb begin
    in_ready = 1'b0;
    case (in_sel)
      SEL_DROP:  in_ready = 1'b1;
      SEL_BCAST: in_ready = &can_take;
      default:   in_ready = |(can_take & sel_hit);
    endcase
  end

  // Sticky bad-select flag and saturating drop counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_sel_reg  <= 1'b0;
      drop_cnt_reg <= '0;
    end else if (drop_accept) begin
      err_sel_reg <= 1'b1;
      if (drop_cnt_reg != '1) begin
        drop_cnt_reg <= drop_cnt_reg + 1'b1;
      end
    end
  end

  assign err_sel  = err_sel_reg;
  assign drop_cnt = drop_cnt_reg;

endmodule

// File: doc/demux6_router.md
# demux6_router

Six-way 64-bit result distributor: accepts one word per cycle with a 3-bit destination select and routes it to one of six registered output lanes, or to all six. It is the inverse of the datapath's six-input 64-bit selector: one source fanned out to six consumers. Each lane has a one-entry buffer with a valid/ready handshake, so a stalled consumer blocks only traffic aimed at its own lane.

## Interface
- `WIDTH`, 64, data width per word and per lane.
- `N_OUT`, 6, number of output lanes; fixed at 6 by the select encoding.
- `CNT_W`, 8, width of the drop counter.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `in_valid`  in  1  input word present.
- `in_ready`  out  1  router can take the input word this cycle.
- `in_data`  in  WIDTH  word to route.
- `in_sel`  in  3  destination select:
  - 0–5: lane index.
  - 6: drop.
  - 7: broadcast to all lanes.
- `out_valid`  out  N_OUT  per-lane data valid.
- `out_ready`  in  N_OUT  per-lane consumer ready.
- `out_data`  out  N_OUT*WIDTH  lane i occupies bits [i*WIDTH +: WIDTH].
- `err_sel`  out  1  sticky; set when a word with `in_sel`==6 is accepted.
- `drop_cnt`  out  CNT_W  saturating count of dropped words.

## Operation
- Each lane has two states:
  - EMPTY: `out_valid`[i]=0.
  - FULL: `out_valid`[i]=1 and the buffer holds one word.
- Lane i can accept a word when `can_take`[i] = !`out_valid`[i] || `out_ready`[i].
- `in_ready` is combinational from `in_sel` and the `can_take` vector:
  - `in_sel` 0–5: `in_ready` = `can_take`[`in_sel`].
  - `in_sel` 6: `in_ready` = 1; a drop never stalls.
  - `in_sel` 7: `in_ready` = AND of all six `can_take` bits; broadcast is all-or-nothing.
- Accept occurs when `in_valid` && `in_ready`.
  - Lane sel: that lane loads `in_data` and goes FULL.
  - Broadcast: all six lanes load `in_data` and go FULL.
  - Drop: no lane changes; `err_sel` is set to 1; `drop_cnt` increments and saturates at 2^CNT_W−1.
- Lane pop: when `out_valid`[i] && `out_ready`[i] and the lane does not load in the same cycle, the lane goes EMPTY.
- Simultaneous pop and load on the same lane: the lane stays FULL with the new word. This gives full throughput of one word per cycle per lane.
- While a lane is FULL and not ready, `out_data` lane i holds stable.
- `in_sel`/`in_data` are ignored when `in_valid`=0. No state changes.
- An input blocked by `in_ready`=0 is not consumed; the producer holds it.
- `err_sel` and `drop_cnt` clear only on `reset`.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `err_sel`=0, `drop_cnt`=0. `in_ready` then follows the rules above; with all lanes EMPTY it is 1 for every `in_sel`.
- Reset mid-operation discards all buffered words at the next rising edge. Any word presented in the reset cycle is not accepted.
- Latency: a word accepted at edge N is visible on `out_valid`/`out_data` after edge N.
- Combinational paths:
  - `in_sel`, `out_ready` → `in_ready`.
  - No path from `in_data` to any output.
- `out_valid`, `out_data`, `err_sel` and `drop_cnt` are registered.

## Structure
- Package `demux6_pkg` holds:
  - `WIDTH`, `N_OUT`;
  - select constants `SEL_DROP`=3'd6 and `SEL_BCAST`=3'd7;
  - `typedef enum logic {LANE_EMPTY, LANE_FULL} lane_state_t`.
- Sub-module `demux_lane` implements one lane:
  - one-entry buffer with a load input and valid/ready;
  - exports `can_take`.
- Instantiate `demux_lane` six times in a generate loop. The top level holds select decode, the `in_ready` logic, `err_sel` and `drop_cnt`.

## Test plan
- **Reset then route to lane 3.** Stimulus: `in_sel`=3, `in_data`=64'hDEAD_BEEF_0000_0003, `out_ready`=0. Required:
  - `out_valid`=6'b001000 next cycle;
  - lane 3 data matches;
  - a second word to lane 3 sees `in_ready`=0 until `out_ready`[3]=1.
- **Back-to-back streaming to lane 0.** Stimulus: 8 words 1..8, `out_ready`[0]=1. Required: words emerge in order, one per cycle, with `in_ready` held at 1.
- **Broadcast with lane 5 stalled.** Stimulus: lane 5 FULL, `out_ready`[5]=0, `in_sel`=7. Required:
  - `in_ready`=0 and no lane loads;
  - after `out_ready`[5]=1, all six lanes show the broadcast word.
- **Drop path.** Stimulus: 300 words with `in_sel`=6. Required:
  - `in_ready`=1 throughout;
  - no `out_valid` rises;
  - `err_sel`=1 after the first accept;
  - `drop_cnt` saturates at 255.
- **Reset mid-operation.** Stimulus: lanes 1 and 4 FULL; assert `reset` for one cycle. Required: `out_valid`=0, `err_sel`=0, `drop_cnt`=0 after the edge.
- **Isolation.** Stimulus: lane 2 stalled, words sent to lane 2 and then lane 0. Required: lane 0 word accepted and delivered while lane 2 stays blocked.
